// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle CPU: decodes the IR opcode into datapath selects and strobes,
// sequences each instruction through its states, and counts retired (fetched) instructions.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int COUNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t             state_reg, state_next;
  logic [COUNT_W-1:0] count_reg;
  logic               ready;

  assign ready       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state       = state_reg;
  assign instr_count = count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_write)
        count_reg <= count_reg + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_write  = ready;
        if (ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYP:      state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op == OP_LW)      state_next = MEMRD;
        else if (op == OP_SW) state_next = MEMWR;
        else                  state_next = FETCH;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (ready) state_next = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (ready) state_next = FETCH;
      end
      EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write   = zero;
        state_next = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    // Async reset must also silence the decode so no strobe is visible before the next edge.
    if (reset) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: expected per-cycle state/controls/count are queued
// as stimulus is driven and compared on the falling edge.
module tb_multicycle_control_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op;
  logic ir_write, pc_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic illegal_op;
  logic [3:0] state;
  logic [31:0] instr_count;

  logic rst_w;
  logic ir_write_w, pc_write_w, mem_read_w, mem_write_w, iord_w, reg_write_w, reg_dst_w;
  logic mem_to_reg_w, alu_src_a_w, illegal_op_w;
  logic [1:0] alu_src_b_w, alu_op_w, pc_src_w;
  logic [3:0] state_w;
  logic [3:0] instr_count_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_count = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  // Narrow counter and ignored handshake: a stream of jumps with mem_ready tied low.
  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0), .COUNT_W(4)) dut_w (
    .clk(clk), .reset(rst_w), .op(JMP), .zero(1'b0), .mem_ready(1'b0),
    .ir_write(ir_write_w), .pc_write(pc_write_w), .mem_read(mem_read_w), .mem_write(mem_write_w),
    .iord(iord_w), .reg_write(reg_write_w), .reg_dst(reg_dst_w), .mem_to_reg(mem_to_reg_w),
    .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w), .pc_src(pc_src_w),
    .illegal_op(illegal_op_w), .state(state_w), .instr_count(instr_count_w)
  );

  wire [15:0] ctrl = {ir_write, pc_write, mem_read, mem_write, iord, reg_write, reg_dst,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
  wire [15:0] ctrl_w = {ir_write_w, pc_write_w, mem_read_w, mem_write_w, iord_w, reg_write_w,
                        reg_dst_w, mem_to_reg_w, alu_src_a_w, alu_src_b_w, alu_op_w, pc_src_w,
                        illegal_op_w};

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] pk(input logic irw, pcw, mr, mw, io, rw, rd, m2r, a,
                                     input logic [1:0] b, aop, ps, input logic ill);
    return {irw, pcw, mr, mw, io, rw, rd, m2r, a, b, aop, ps, ill};
  endfunction

  // Expected controls from the state table.
  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy, z, input logic [5:0] opc);
    logic legal;
    legal = (opc == LW) || (opc == SW) || (opc == RT) || (opc == BEQ) || (opc == ADDI) || (opc == JMP);
    case (st)
      0:  return pk(rdy, rdy, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      1:  return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, !legal);
      2:  return pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      3:  return pk(0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4:  return pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      5:  return pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      6:  return pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      7:  return pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      8:  return pk(0, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      9:  return pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      10: return pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      11: return pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
      default: return 16'h0;
    endcase
  endfunction

  // One clock of stimulus: drive inputs just after the edge and queue what the DUT must show.
  task automatic cyc(input int st, input logic rdy, input logic z, input logic [5:0] opc);
    exp_t e;
    @(posedge clk);
    #1;
    op = opc;
    mem_ready = rdy;
    zero = z;
    e.st = 4'(st);
    e.ctrl = exp_ctrl(st, rdy, z, opc);
    e.cnt = exp_count;
    sb.push_back(e);
    if (st == 0 && rdy) exp_count = exp_count + 1;
  endtask

  task automatic run_instr(input logic [5:0] opc, input logic z, input int fetch_waits,
                           input int mem_waits);
    for (int i = 0; i < fetch_waits; i++) cyc(0, 1'b0, z, opc);
    cyc(0, 1'b1, z, opc);
    cyc(1, 1'($urandom_range(1)), z, opc);
    case (opc)
      LW: begin
        cyc(2, 1'b0, z, opc);
        for (int i = 0; i < mem_waits; i++) cyc(3, 1'b0, z, opc);
        cyc(3, 1'b1, z, opc);
        cyc(4, 1'b0, z, opc);
      end
      SW: begin
        cyc(2, 1'b1, z, opc);
        for (int i = 0; i < mem_waits; i++) cyc(5, 1'b0, z, opc);
        cyc(5, 1'b1, z, opc);
      end
      RT:   begin cyc(6, 1'b0, z, opc); cyc(7, 1'b0, z, opc); end
      BEQ:  cyc(8, 1'b0, z, opc);
      ADDI: begin cyc(9, 1'b0, z, opc); cyc(10, 1'b0, z, opc); end
      JMP:  cyc(11, 1'b0, z, opc);
      default: ;
    endcase
    $display("instr op=%b zero=%0d fetch_waits=%0d mem_waits=%0d queued, count=%0d",
             opc, z, fetch_waits, mem_waits, exp_count);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_value($sformatf("state@%0d", e.st), 64'(state), 64'(e.st));
      check_value($sformatf("ctrl@%0d", e.st), 64'(ctrl), 64'(e.ctrl));
      check_value($sformatf("count@%0d", e.st), 64'(instr_count), 64'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rst_w = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    check_value("reset_ctrl", 64'(ctrl), 64'h0);
    check_value("reset_state", 64'(state), 64'h0);
    check_value("reset_w_ctrl", 64'(ctrl_w), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(LW, 1'b0, 0, 0);
    run_instr(SW, 1'b0, 0, 2);
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);
    run_instr(BAD, 1'b0, 0, 0);
    run_instr(RT, 1'b1, 1, 0);
    run_instr(ADDI, 1'b0, 0, 0);
    run_instr(JMP, 1'b0, 2, 0);
    run_instr(LW, 1'b1, 1, 3);

    // Reset in the middle of a stalled store.
    cyc(0, 1'b1, 1'b0, SW);
    cyc(1, 1'b0, 1'b0, SW);
    cyc(2, 1'b0, 1'b0, SW);
    cyc(5, 1'b0, 1'b0, SW);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_value("midrst_ctrl", 64'(ctrl), 64'h0);
    check_value("midrst_state", 64'(state), 64'h0);
    check_value("midrst_count", 64'(instr_count), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check_value("midrst_hold_ctrl", 64'(ctrl), 64'h0);
    reset = 1'b0;
    exp_count = 0;
    #1;
    check_value("postrst_state", 64'(state), 64'h0);
    check_value("postrst_count", 64'(instr_count), 64'h0);

    run_instr(ADDI, 1'b0, 0, 0);
    run_instr(SW, 1'b1, 0, 0);
    @(negedge clk);
    #1;
    check_value("sb_empty", 64'(sb.size()), 64'h0);

    // 17 jumps of 3 cycles each on the 4-bit counter instance.
    @(negedge clk);
    rst_w = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_value("w_first_state", 64'(state_w), 64'd1);
    check_value("w_first_count", 64'(instr_count_w), 64'd1);
    repeat (47) @(posedge clk);
    @(negedge clk);
    check_value("w_wrap0_count", 64'(instr_count_w), 64'd0);
    check_value("w_wrap0_state", 64'(state_w), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("w_wrap1_count", 64'(instr_count_w), 64'd1);
    check_value("w_wrap1_state", 64'(state_w), 64'd0);
    $display("jump stream on 4-bit counter: count=%0d state=%0d", instr_count_w, state_w);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
